// File: rtl/wb_stage_multilane.sv
// MEM/WB pipeline latch and multi-lane writeback: source select, same-destination
// conflict suppression, in-order halt and retire counting. Optional WB_BYPASS_EN adds decode bypass.
module wb_stage_multilane #(
  parameter int LANES   = 2,
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 32
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      stall,
  input  logic                      flush,
  input  logic [LANES-1:0]          mem_valid,
  input  logic [2*LANES-1:0]        mem_memtoreg,
  input  logic [DATA_W*LANES-1:0]   mem_port_o,
  input  logic [DATA_W*LANES-1:0]   mem_npc,
  input  logic [DATA_W*LANES-1:0]   mem_dmemload,
  input  logic [DATA_W*LANES-1:0]   mem_imm_ext,
  input  logic [LANES-1:0]          mem_regwen,
  input  logic [RADDR_W*LANES-1:0]  mem_rw,
  input  logic [LANES-1:0]          mem_halt,
  output logic [LANES-1:0]          wb_regwen,
  output logic [RADDR_W*LANES-1:0]  wb_rw,
  output logic [DATA_W*LANES-1:0]   wb_port_w,
  output logic                      wb_halt,
  output logic [CNT_W-1:0]          retire_cnt,
  input  logic [2*RADDR_W-1:0]      byp_rsel,
  output logic [1:0]                byp_hit,
  output logic [2*DATA_W-1:0]       byp_data
);

  logic [LANES-1:0]         valid_r;
  logic [2*LANES-1:0]       sel_r;
  logic [DATA_W*LANES-1:0]  port_o_r;
  logic [DATA_W*LANES-1:0]  npc_r;
  logic [DATA_W*LANES-1:0]  dmemload_r;
  logic [DATA_W*LANES-1:0]  imm_r;
  logic [LANES-1:0]         regwen_r;
  logic [RADDR_W*LANES-1:0] rw_r;
  logic [LANES-1:0]         halt_r;
  logic                     halt_sticky_r;
  logic [CNT_W-1:0]         cnt_r;

  logic [LANES-1:0]         killed_s;
  logic [LANES-1:0]         pre_wen_s;
  logic [LANES-1:0]         wen_s;
  logic                     halt_hit_s;
  logic [CNT_W-1:0]         live_cnt_s;
  logic [DATA_W*LANES-1:0]  port_w_s;

  // Pipeline latch: flush clears valids (and beats stall), stall holds, else capture.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_r    <= '0;
      sel_r      <= '0;
      port_o_r   <= '0;
      npc_r      <= '0;
      dmemload_r <= '0;
      imm_r      <= '0;
      regwen_r   <= '0;
      rw_r       <= '0;
      halt_r     <= '0;
    end else if (flush) begin
      valid_r <= '0;
    end else if (!stall) begin
      valid_r    <= mem_valid;
      sel_r      <= mem_memtoreg;
      port_o_r   <= mem_port_o;
      npc_r      <= mem_npc;
      dmemload_r <= mem_dmemload;
      imm_r      <= mem_imm_ext;
      regwen_r   <= mem_regwen;
      rw_r       <= mem_rw;
      halt_r     <= mem_halt;
    end
  end

  // Sticky halt and retire counter; both freeze once halted.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      halt_sticky_r <= 1'b0;
      cnt_r         <= '0;
    end else begin
      if (!stall && !halt_sticky_r) begin
        cnt_r <= cnt_r + live_cnt_s;
      end
      if (halt_hit_s) begin
        halt_sticky_r <= 1'b1;
      end
    end
  end

  // Halt kills every younger lane in the bundle; the halt lane itself still retires.
  always_comb begin : halt_scan
    logic seen;
    seen       = 1'b0;
    killed_s   = '0;
    pre_wen_s  = '0;
    live_cnt_s = '0;
    for (int i = 0; i < LANES; i++) begin
      killed_s[i]  = seen;
      pre_wen_s[i] = valid_r[i] & regwen_r[i] & (rw_r[i*RADDR_W +: RADDR_W] != {RADDR_W{1'b0}})
                     & ~seen & ~halt_sticky_r;
      if (valid_r[i] && !seen) begin
        live_cnt_s = live_cnt_s + CNT_W'(1);
      end else begin
        live_cnt_s = live_cnt_s;
      end
      seen = seen | (valid_r[i] & halt_r[i]);
    end
    halt_hit_s = seen;
  end

  // An older lane yields to any younger effective writer of the same register.
  always_comb begin
    wen_s = pre_wen_s;
    for (int i = 0; i < LANES; i++) begin
      for (int j = i + 1; j < LANES; j++) begin
        wen_s[i] = wen_s[i] & ~(pre_wen_s[j] &
                   (rw_r[j*RADDR_W +: RADDR_W] == rw_r[i*RADDR_W +: RADDR_W]));
      end
    end
  end

  // Per-lane write data source select.
  always_comb begin
    port_w_s = '0;
    for (int i = 0; i < LANES; i++) begin
      case (sel_r[2*i +: 2])
        2'd0:    port_w_s[i*DATA_W +: DATA_W] = port_o_r[i*DATA_W +: DATA_W];
        2'd1:    port_w_s[i*DATA_W +: DATA_W] = npc_r[i*DATA_W +: DATA_W];
        2'd2:    port_w_s[i*DATA_W +: DATA_W] = dmemload_r[i*DATA_W +: DATA_W];
        2'd3:    port_w_s[i*DATA_W +: DATA_W] = imm_r[i*DATA_W +: DATA_W];
        default: port_w_s[i*DATA_W +: DATA_W] = port_o_r[i*DATA_W +: DATA_W];
      endcase
    end
  end

  assign wb_regwen  = wen_s;
  assign wb_rw      = rw_r;
  assign wb_port_w  = port_w_s;
  assign wb_halt    = halt_sticky_r;
  assign retire_cnt = cnt_r;

`ifdef WB_BYPASS_EN
  // Decode bypass: scanning oldest to youngest lets the youngest match win.
  always_comb begin
    byp_hit  = 2'b00;
    byp_data = '0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < LANES; i++) begin
        if (wen_s[i] && (byp_rsel[p*RADDR_W +: RADDR_W] != {RADDR_W{1'b0}}) &&
            (byp_rsel[p*RADDR_W +: RADDR_W] == rw_r[i*RADDR_W +: RADDR_W])) begin
          byp_hit[p]                   = 1'b1;
          byp_data[p*DATA_W +: DATA_W] = port_w_s[i*DATA_W +: DATA_W];
        end else begin
          byp_hit[p] = byp_hit[p];
        end
      end
    end
  end
`else
  logic byp_unused_s;
  assign byp_unused_s = ^byp_rsel;
  assign byp_hit      = 2'b00;
  assign byp_data     = '0;
`endif

endmodule

// File: tb/tb_wb_stage_multilane.sv
// Self-checking bench for wb_stage_multilane: directed scenarios plus randomized
// traffic compared against a lane-list reference model.
module tb_wb_stage_multilane;
  localparam int L  = 2;
  localparam int DW = 32;
  localparam int RW = 5;
  localparam int CW = 32;

  logic CLK = 1'b0;
  logic RST, stall, flush;
  logic [L-1:0]    mem_valid, mem_regwen, mem_halt;
  logic [2*L-1:0]  mem_memtoreg;
  logic [DW*L-1:0] mem_port_o, mem_npc, mem_dmemload, mem_imm_ext;
  logic [RW*L-1:0] mem_rw;
  logic [L-1:0]    wb_regwen;
  logic [RW*L-1:0] wb_rw;
  logic [DW*L-1:0] wb_port_w;
  logic            wb_halt;
  logic [CW-1:0]   retire_cnt;
  logic [2*RW-1:0] byp_rsel;
  logic [1:0]      byp_hit;
  logic [2*DW-1:0] byp_data;

  int checks = 0;
  int fails  = 0;

  wb_stage_multilane #(.LANES(L), .DATA_W(DW), .RADDR_W(RW), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_memtoreg(mem_memtoreg), .mem_port_o(mem_port_o),
    .mem_npc(mem_npc), .mem_dmemload(mem_dmemload), .mem_imm_ext(mem_imm_ext),
    .mem_regwen(mem_regwen), .mem_rw(mem_rw), .mem_halt(mem_halt),
    .wb_regwen(wb_regwen), .wb_rw(wb_rw), .wb_port_w(wb_port_w), .wb_halt(wb_halt),
    .retire_cnt(retire_cnt), .byp_rsel(byp_rsel), .byp_hit(byp_hit), .byp_data(byp_data)
  );

  always #5 CLK = ~CLK;

  // Reference model: what sits in the latch, plus architectural halt/count.
  logic          m_v[L];
  logic [1:0]    m_sel[L];
  logic [DW-1:0] m_src[L][4];
  logic          m_we[L];
  logic [RW-1:0] m_rw[L];
  logic          m_h[L];
  logic          m_whalt;
  logic [CW-1:0] m_cnt;
  logic [L-1:0]    e_wen;
  logic [RW*L-1:0] e_rw;
  logic [DW*L-1:0] e_data;
  logic [1:0]      e_hit;
  logic [2*DW-1:0] e_byp;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 1'b0; flush = 1'b0;
    mem_valid = '0; mem_regwen = '0; mem_halt = '0; mem_memtoreg = '0;
    mem_port_o = '0; mem_npc = '0; mem_dmemload = '0; mem_imm_ext = '0;
    mem_rw = '0; byp_rsel = '0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    clear_inputs();
    #2;
    RST = 1'b0;
  endtask

  // Put value d on the selected source; the other three sources carry noise.
  task automatic set_lane(input int i, input logic v, input logic [1:0] sel, input logic [DW-1:0] d,
                          input logic we, input logic [RW-1:0] rw, input logic h);
    mem_valid[i] = v;
    mem_memtoreg[2*i +: 2] = sel;
    mem_port_o[i*DW +: DW] = $urandom;
    mem_npc[i*DW +: DW] = $urandom;
    mem_dmemload[i*DW +: DW] = $urandom;
    mem_imm_ext[i*DW +: DW] = $urandom;
    case (sel)
      2'd0: mem_port_o[i*DW +: DW] = d;
      2'd1: mem_npc[i*DW +: DW] = d;
      2'd2: mem_dmemload[i*DW +: DW] = d;
      default: mem_imm_ext[i*DW +: DW] = d;
    endcase
    mem_regwen[i] = we;
    mem_rw[i*RW +: RW] = rw;
    mem_halt[i] = h;
  endtask

  function automatic int first_halt();
    for (int i = 0; i < L; i++) if (m_v[i] && m_h[i]) return i;
    return L;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < L; i++) begin
      m_v[i] = 1'b0; m_sel[i] = 2'd0; m_we[i] = 1'b0; m_rw[i] = '0; m_h[i] = 1'b0;
      for (int s = 0; s < 4; s++) m_src[i][s] = '0;
    end
    m_whalt = 1'b0;
    m_cnt = '0;
  endtask

  task automatic model_edge();
    int fh, live;
    fh = first_halt();
    live = 0;
    for (int i = 0; i < L; i++) if (m_v[i] && i <= fh) live++;
    if (!stall && !m_whalt) m_cnt = m_cnt + CW'(live);
    if (fh < L) m_whalt = 1'b1;
    if (flush) begin
      for (int i = 0; i < L; i++) m_v[i] = 1'b0;
    end else if (!stall) begin
      for (int i = 0; i < L; i++) begin
        m_v[i] = mem_valid[i]; m_sel[i] = mem_memtoreg[2*i +: 2];
        m_src[i][0] = mem_port_o[i*DW +: DW]; m_src[i][1] = mem_npc[i*DW +: DW];
        m_src[i][2] = mem_dmemload[i*DW +: DW]; m_src[i][3] = mem_imm_ext[i*DW +: DW];
        m_we[i] = mem_regwen[i]; m_rw[i] = mem_rw[i*RW +: RW]; m_h[i] = mem_halt[i];
      end
    end
  endtask

  // Youngest lane claims a register first; older lanes to a claimed register lose.
  task automatic model_expect();
    int fh;
    logic [31:0] claimed;
    logic [RW-1:0] sel_p;
    fh = first_halt();
    claimed = '0;
    e_wen = '0;
    for (int i = L - 1; i >= 0; i--) begin
      e_rw[i*RW +: RW] = m_rw[i];
      e_data[i*DW +: DW] = m_src[i][m_sel[i]];
      if (!m_whalt && m_v[i] && i <= fh && m_we[i] && m_rw[i] != 0 && !claimed[m_rw[i]]) begin
        e_wen[i] = 1'b1;
        claimed[m_rw[i]] = 1'b1;
      end
    end
    e_hit = 2'b00;
    e_byp = '0;
`ifdef WB_BYPASS_EN
    for (int p = 0; p < 2; p++) begin
      sel_p = byp_rsel[p*RW +: RW];
      for (int i = L - 1; i >= 0; i--) begin
        if (!e_hit[p] && e_wen[i] && sel_p != 0 && m_rw[i] == sel_p) begin
          e_hit[p] = 1'b1;
          e_byp[p*DW +: DW] = e_data[i*DW +: DW];
        end
      end
    end
`else
    sel_p = '0;
`endif
  endtask

  task automatic test_reset();
    RST = 1'b1;
    clear_inputs();
    #1;
    checks++; if (wb_regwen !== 2'b00) begin fails++; $display("FAIL reset_wen: got %b expected 00", wb_regwen); end
    checks++; if (wb_port_w !== 64'h0) begin fails++; $display("FAIL reset_data: got %h expected 0", wb_port_w); end
    checks++; if (retire_cnt !== 32'd0 || wb_halt !== 1'b0) begin fails++; $display("FAIL reset_cnt_halt: got %0d/%b expected 0/0", retire_cnt, wb_halt); end
    RST = 1'b0;
    set_lane(0, 1'b1, 2'd0, 32'hAAAA_0001, 1'b1, 5'd1, 1'b0);
    set_lane(1, 1'b1, 2'd0, 32'hAAAA_0002, 1'b1, 5'd2, 1'b0);
    tick();
    checks++; if (wb_regwen !== 2'b11) begin fails++; $display("FAIL pre_reset_wen: got %b expected 11", wb_regwen); end
    tick();
    checks++; if (retire_cnt !== 32'd2) begin fails++; $display("FAIL pre_reset_cnt: got %0d expected 2", retire_cnt); end
    RST = 1'b1;
    #1;
    checks++; if (wb_regwen !== 2'b00 || wb_rw !== 10'd0 || wb_port_w !== 64'h0) begin fails++; $display("FAIL midrun_reset_outs: got %b %h %h expected 00 0 0", wb_regwen, wb_rw, wb_port_w); end
    checks++; if (retire_cnt !== 32'd0) begin fails++; $display("FAIL midrun_reset_cnt: got %0d expected 0", retire_cnt); end
    RST = 1'b0;
  endtask

  task automatic test_select();
    do_reset();
    set_lane(0, 1'b1, 2'd2, 32'hDEAD_BEEF, 1'b1, 5'd3, 1'b0);
    set_lane(1, 1'b1, 2'd3, 32'h0000_1234, 1'b1, 5'd4, 1'b0);
    tick();
    checks++; if (wb_regwen !== 2'b11) begin fails++; $display("FAIL sel_wen: got %b expected 11", wb_regwen); end
    checks++; if (wb_port_w !== 64'h0000_1234_DEAD_BEEF) begin fails++; $display("FAIL sel_data_ld_imm: got %h expected 00001234deadbeef", wb_port_w); end
    checks++; if (wb_rw !== {5'd4, 5'd3}) begin fails++; $display("FAIL sel_rw: got %h expected 083", wb_rw); end
    set_lane(0, 1'b1, 2'd0, 32'h0BAD_F00D, 1'b1, 5'd8, 1'b0);
    set_lane(1, 1'b1, 2'd1, 32'h0000_4004, 1'b1, 5'd9, 1'b0);
    tick();
    checks++; if (wb_port_w !== 64'h0000_4004_0BAD_F00D) begin fails++; $display("FAIL sel_data_alu_npc: got %h expected 000040040badf00d", wb_port_w); end
    checks++; if (retire_cnt !== 32'd2) begin fails++; $display("FAIL sel_cnt: got %0d expected 2", retire_cnt); end
    clear_inputs();
    tick();
    checks++; if (retire_cnt !== 32'd4) begin fails++; $display("FAIL sel_cnt2: got %0d expected 4", retire_cnt); end
  endtask

  task automatic test_conflict();
    do_reset();
    set_lane(0, 1'b1, 2'd0, 32'h0000_0111, 1'b1, 5'd7, 1'b0);
    set_lane(1, 1'b1, 2'd0, 32'h0000_0222, 1'b1, 5'd7, 1'b0);
    tick();
    checks++; if (wb_regwen !== 2'b10) begin fails++; $display("FAIL conflict_wen: got %b expected 10", wb_regwen); end
    checks++; if (wb_port_w[2*DW-1:DW] !== 32'h0000_0222) begin fails++; $display("FAIL conflict_data: got %h expected 00000222", wb_port_w[2*DW-1:DW]); end
    set_lane(0, 1'b1, 2'd0, 32'h0000_0333, 1'b1, 5'd0, 1'b0);
    set_lane(1, 1'b1, 2'd0, 32'h0000_0444, 1'b0, 5'd6, 1'b0);
    tick();
    checks++; if (wb_regwen !== 2'b00) begin fails++; $display("FAIL r0_write: got %b expected 00", wb_regwen); end
  endtask

  task automatic test_halt();
    do_reset();
    set_lane(0, 1'b1, 2'd0, 32'h0000_0001, 1'b1, 5'd1, 1'b1);
    set_lane(1, 1'b1, 2'd0, 32'h0000_0002, 1'b1, 5'd2, 1'b0);
    tick();
    checks++; if (wb_regwen !== 2'b01 || wb_halt !== 1'b0) begin fails++; $display("FAIL halt_bundle: got %b/%b expected 01/0", wb_regwen, wb_halt); end
    set_lane(0, 1'b1, 2'd0, 32'h0000_0003, 1'b1, 5'd3, 1'b0);
    set_lane(1, 1'b1, 2'd0, 32'h0000_0004, 1'b1, 5'd4, 1'b0);
    tick();
    checks++; if (wb_halt !== 1'b1 || retire_cnt !== 32'd1) begin fails++; $display("FAIL halt_set: got %b/%0d expected 1/1", wb_halt, retire_cnt); end
    checks++; if (wb_regwen !== 2'b00) begin fails++; $display("FAIL halt_block: got %b expected 00", wb_regwen); end
    tick();
    checks++; if (retire_cnt !== 32'd1 || wb_regwen !== 2'b00) begin fails++; $display("FAIL halt_frozen: got %0d/%b expected 1/00", retire_cnt, wb_regwen); end
  endtask

  task automatic test_stall_flush();
    do_reset();
    set_lane(0, 1'b1, 2'd0, 32'h0000_0A01, 1'b1, 5'd1, 1'b0);
    set_lane(1, 1'b1, 2'd0, 32'h0000_0A02, 1'b1, 5'd2, 1'b0);
    tick();
    stall = 1'b1; flush = 1'b1;
    tick();
    checks++; if (wb_regwen !== 2'b00) begin fails++; $display("FAIL stall_flush_wen: got %b expected 00", wb_regwen); end
    stall = 1'b0; flush = 1'b0;
    set_lane(0, 1'b1, 2'd0, 32'h0000_0B05, 1'b1, 5'd5, 1'b0);
    set_lane(1, 1'b1, 2'd0, 32'h0000_0B06, 1'b1, 5'd6, 1'b0);
    tick();
    stall = 1'b1;
    set_lane(0, 1'b1, 2'd0, 32'h0000_0C0C, 1'b1, 5'd12, 1'b0);
    set_lane(1, 1'b1, 2'd0, 32'h0000_0C0D, 1'b1, 5'd13, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (wb_regwen !== 2'b11 || wb_port_w !== 64'h0000_0B06_0000_0B05 || wb_rw !== {5'd6, 5'd5}) begin
        fails++; $display("FAIL stall_hold: got %b %h %h expected 11 00000b0600000b05 0c5", wb_regwen, wb_port_w, wb_rw); end
      checks++; if (retire_cnt !== 32'd0) begin fails++; $display("FAIL stall_cnt: got %0d expected 0", retire_cnt); end
    end
    stall = 1'b0;
    clear_inputs();
    tick();
    checks++; if (retire_cnt !== 32'd2) begin fails++; $display("FAIL unstall_cnt: got %0d expected 2", retire_cnt); end
  endtask

  task automatic test_bypass();
    do_reset();
    set_lane(0, 1'b1, 2'd0, 32'h0000_0011, 1'b1, 5'd5, 1'b0);
    set_lane(1, 1'b1, 2'd0, 32'h0000_0055, 1'b1, 5'd5, 1'b0);
    byp_rsel = {5'd5, 5'd5};
    tick();
`ifdef WB_BYPASS_EN
    checks++; if (byp_hit !== 2'b11 || byp_data !== 64'h0000_0055_0000_0055) begin fails++; $display("FAIL bypass_hit: got %b %h expected 11 0000005500000055", byp_hit, byp_data); end
    byp_rsel = {5'd0, 5'd5};
    #1;
    checks++; if (byp_hit !== 2'b01) begin fails++; $display("FAIL bypass_r0: got %b expected 01", byp_hit); end
`else
    checks++; if (byp_hit !== 2'b00 || byp_data !== 64'h0) begin fails++; $display("FAIL bypass_off: got %b %h expected 00 0", byp_hit, byp_data); end
`endif
  endtask

  task automatic test_random();
    do_reset();
    model_reset();
    for (int n = 0; n < 600; n++) begin
      if (n % 50 == 49) begin
        do_reset();
        model_reset();
      end
      mem_valid = L'($urandom); mem_regwen = L'($urandom); mem_memtoreg = (2*L)'($urandom);
      mem_port_o = {$urandom, $urandom}; mem_npc = {$urandom, $urandom};
      mem_dmemload = {$urandom, $urandom}; mem_imm_ext = {$urandom, $urandom};
      for (int i = 0; i < L; i++) begin
        mem_rw[i*RW +: RW] = RW'($urandom_range(0, 3));
        mem_halt[i] = ($urandom_range(0, 19) == 0);
      end
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 7) == 0);
      byp_rsel = {RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3))};
      @(posedge CLK);
      model_edge();
      #1;
      model_expect();
      checks++; if (wb_regwen !== e_wen) begin fails++; $display("FAIL rnd_wen[%0d]: got %b expected %b", n, wb_regwen, e_wen); end
      checks++; if (wb_rw !== e_rw) begin fails++; $display("FAIL rnd_rw[%0d]: got %h expected %h", n, wb_rw, e_rw); end
      checks++; if (wb_port_w !== e_data) begin fails++; $display("FAIL rnd_data[%0d]: got %h expected %h", n, wb_port_w, e_data); end
      checks++; if (wb_halt !== m_whalt) begin fails++; $display("FAIL rnd_halt[%0d]: got %b expected %b", n, wb_halt, m_whalt); end
      checks++; if (retire_cnt !== m_cnt) begin fails++; $display("FAIL rnd_cnt[%0d]: got %0d expected %0d", n, retire_cnt, m_cnt); end
      checks++; if (byp_hit !== e_hit || byp_data !== e_byp) begin fails++; $display("FAIL rnd_byp[%0d]: got %b %h expected %b %h", n, byp_hit, byp_data, e_hit, e_byp); end
    end
  endtask

  initial begin
    test_reset();
    test_select();
    test_conflict();
    test_halt();
    test_stall_flush();
    test_bypass();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
